// File: rtl/des_pkg.sv
// Shared DES key-schedule constants: permutation tables, shift schedule, FSM states.
package des_pkg;

  localparam int unsigned KEY_W    = 64;
  localparam int unsigned CD_W     = 56;
  localparam int unsigned SUBKEY_W = 48;
  localparam int unsigned HALF_W   = 28;
  localparam int unsigned ROUNDS   = 16;
  localparam int unsigned ROUND_W  = 4;

  localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(ROUNDS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // PC-1: entry j gives the key bit (1 = MSB) feeding C/D bit j+1.
  localparam int unsigned PC1_TAB [CD_W] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  // PC-2: entry j gives the C/D bit (1 = MSB) feeding subkey bit j+1.
  localparam int unsigned PC2_TAB [SUBKEY_W] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // Encrypt left-rotation amount applied before issuing subkey index i.
  localparam int unsigned ENC_SHIFT [ROUNDS] = '{
    1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1
  };

  // Rotate a 28-bit half toward bit 1 (the MSB) by 1 or 2 places.
  function automatic logic [HALF_W:1] rotl_half(input logic [HALF_W:1] x, input logic [1:0] n);
    case (n)
      2'd1:    return {x[HALF_W-1:1], x[HALF_W]};
      2'd2:    return {x[HALF_W-2:1], x[HALF_W:HALF_W-1]};
      default: return x;
    endcase
  endfunction

  // Rotate a 28-bit half away from bit 1 by 1 or 2 places.
  function automatic logic [HALF_W:1] rotr_half(input logic [HALF_W:1] x, input logic [1:0] n);
    case (n)
      2'd1:    return {x[1], x[HALF_W:2]};
      2'd2:    return {x[2:1], x[HALF_W:3]};
      default: return x;
    endcase
  endfunction

endpackage

// File: rtl/des_key_schedule_if.sv
// Launch and subkey handshake bundle between a key source, the schedule and the round datapath.
interface des_key_schedule_if;
  import des_pkg::*;

  logic [KEY_W:1]         Key_Input;
  logic                   Start;
  logic                   Decrypt;
  logic                   Start_Ready;
  logic [SUBKEY_W:1]      Subkey_Out;
  logic [ROUND_W-1:0]     Round_Out;
  logic                   Subkey_Valid;
  logic                   Subkey_Ready;
  logic                   Subkey_Last;
  logic                   Busy;

  modport master (
    output Key_Input, Start, Decrypt, Subkey_Ready,
    input  Start_Ready, Subkey_Out, Round_Out, Subkey_Valid, Subkey_Last, Busy
  );

  modport slave (
    input  Key_Input, Start, Decrypt, Subkey_Ready,
    output Start_Ready, Subkey_Out, Round_Out, Subkey_Valid, Subkey_Last, Busy
  );

endinterface

// File: rtl/des_pc2.sv
// Combinational PC-2 permutation: 56-bit C/D pair to 48-bit round subkey.
module des_pc2
  import des_pkg::*;
(
  input  logic [CD_W:1]     cd_i,
  output logic [SUBKEY_W:1] subkey_o
);

  // Bit 1 is the MSB, so DES position p lives at vector index (width + 1 - p).
  always_comb begin
    subkey_o = '0;
    for (int j = 0; j < SUBKEY_W; j++) begin
      subkey_o[6'(SUBKEY_W - j)] = cd_i[6'(CD_W + 1 - PC2_TAB[6'(j)])];
    end
  end

endmodule

// File: rtl/des_key_schedule.sv
// Iterative DES round-key generator: one PC-2 subkey per handshake, encrypt or decrypt order.
module des_key_schedule
  import des_pkg::*;
#(
  parameter bit ALLOW_RESTART = 1'b0
) (
  input logic               clk,
  input logic               rst,
  des_key_schedule_if.slave bus
);

  state_e              state_q, state_d;
  logic [HALF_W:1]     c_q, c_d;
  logic [HALF_W:1]     d_q, d_d;
  logic [ROUND_W-1:0]  round_q, round_d;
  logic                mode_q, mode_d;

  logic [CD_W:1]       pc1_key;
  logic [SUBKEY_W:1]   subkey;
  logic                running;
  logic                start_ready;
  logic                start_acc;
  logic                sub_acc;

  assign running     = (state_q == RUN);
  assign start_ready = rst & ((state_q == IDLE) | ALLOW_RESTART);
  assign start_acc   = bus.Start & start_ready;
  assign sub_acc     = running & bus.Subkey_Ready;

  // PC-1 on the live key input; parity bits 8,16,..,64 are never selected.
  always_comb begin
    pc1_key = '0;
    for (int j = 0; j < CD_W; j++) begin
      pc1_key[6'(CD_W - j)] = bus.Key_Input[7'(KEY_W + 1 - PC1_TAB[6'(j)])];
    end
  end

  // Next state: launch (priority), advance on acceptance, otherwise hold.
  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    d_d     = d_q;
    round_d = round_q;
    mode_d  = mode_q;

    if (start_acc) begin
      state_d = RUN;
      mode_d  = bus.Decrypt;
      round_d = '0;
      // Decrypt starts from C16D16, which equals C0D0, so no first rotation.
      if (bus.Decrypt) begin
        c_d = pc1_key[CD_W:HALF_W+1];
        d_d = pc1_key[HALF_W:1];
      end else begin
        c_d = rotl_half(pc1_key[CD_W:HALF_W+1], 2'd1);
        d_d = rotl_half(pc1_key[HALF_W:1], 2'd1);
      end
    end else if (sub_acc) begin
      if (round_q == LAST_ROUND) begin
        state_d = IDLE;
      end else begin
        round_d = round_q + ROUND_W'(1);
        if (mode_q) begin
          c_d = rotr_half(c_q, 2'(ENC_SHIFT[LAST_ROUND - round_q]));
          d_d = rotr_half(d_q, 2'(ENC_SHIFT[LAST_ROUND - round_q]));
        end else begin
          c_d = rotl_half(c_q, 2'(ENC_SHIFT[round_q + ROUND_W'(1)]));
          d_d = rotl_half(d_q, 2'(ENC_SHIFT[round_q + ROUND_W'(1)]));
        end
      end
    end
  end

  // State, C/D halves, round counter and mode register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      c_q     <= '0;
      d_q     <= '0;
      round_q <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      round_q <= round_d;
      mode_q  <= mode_d;
    end
  end

  des_pc2 u_pc2 (
    .cd_i     ({c_q, d_q}),
    .subkey_o (subkey)
  );

  // Outputs decode directly from the registered state.
  assign bus.Start_Ready  = start_ready;
  assign bus.Subkey_Out   = subkey;
  assign bus.Round_Out    = round_q;
  assign bus.Subkey_Valid = running;
  assign bus.Subkey_Last  = running & (round_q == LAST_ROUND);
  assign bus.Busy         = running;

endmodule

// File: tb/tb_des_key_schedule.sv
// Scoreboard bench for des_key_schedule: one instance without and one with restart.
module tb_des_key_schedule;

  localparam logic [63:0] KEY0   = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_X  = 64'h0E329232EA6D0D73;
  localparam logic [47:0] K_1    = 48'h1B02EFFC7072;
  localparam logic [47:0] K_2    = 48'h79AED9DBC9E5;
  localparam logic [47:0] K_15   = 48'hBF918D3D3F0A;
  localparam logic [47:0] K_16   = 48'hCB3D8B0E17F5;

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int SH [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  typedef struct {
    logic [47:0] key;
    logic [3:0]  rnd;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   checks = 0;
  int   failures = 0;
  exp_t q_a [$];
  exp_t q_b [$];
  bit          stall [2];
  logic [47:0] hold_key [2];
  logic [3:0]  hold_rnd [2];

  always #5 clk = ~clk;

  des_key_schedule_if if_a ();
  des_key_schedule_if if_b ();

  des_key_schedule #(.ALLOW_RESTART(1'b0)) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (if_a.slave)
  );

  des_key_schedule #(.ALLOW_RESTART(1'b1)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (if_b.slave)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Reference: Kn = PC2(C0D0 with each half rotated left by the sum of the first n shifts).
  function automatic logic [47:0] model_key(input logic [63:0] key, input int n);
    logic [27:0] c, d, rc, rd;
    logic [55:0] cd;
    logic [47:0] k;
    int tot;
    tot = 0;
    for (int j = 0; j < 28; j++) begin
      c[27-j] = key[64-PC1_T[j]];
      d[27-j] = key[64-PC1_T[j+28]];
    end
    for (int i = 0; i < n; i++) tot += SH[i];
    for (int j = 0; j < 28; j++) begin
      rc[27-j] = c[27-((j+tot)%28)];
      rd[27-j] = d[27-((j+tot)%28)];
    end
    cd = {rc, rd};
    for (int j = 0; j < 48; j++) k[47-j] = cd[56-PC2_T[j]];
    return k;
  endfunction

  task automatic push_run(input logic [63:0] key, input logic dec, input bit to_b);
    exp_t e;
    for (int i = 0; i < 16; i++) begin
      e.key  = model_key(key, dec ? 16 - i : i + 1);
      e.rnd  = 4'(i);
      e.last = (i == 15);
      if (to_b) q_b.push_back(e);
      else      q_a.push_back(e);
    end
  endtask

  // One monitor step per instance: stability during stalls, pop-and-compare on acceptance.
  task automatic mon_step(input bit b, input logic vld, input logic rdy, input logic [47:0] key,
                          input logic [3:0] rnd, input logic last, input logic start_pend);
    exp_t e;
    if (vld) begin
      if (stall[b]) begin
        chk(b ? "stall_key_b" : "stall_key_a", 64'(key), 64'(hold_key[b]));
        chk(b ? "stall_rnd_b" : "stall_rnd_a", 64'(rnd), 64'(hold_rnd[b]));
      end
      if (rdy) begin
        stall[b] = 1'b0;
        if ((b ? q_b.size() : q_a.size()) == 0) begin
          fail_now(b ? "unexpected_subkey_b" : "unexpected_subkey_a");
        end else begin
          e = b ? q_b.pop_front() : q_a.pop_front();
          chk(b ? "subkey_b" : "subkey_a", 64'(key), 64'(e.key));
          chk(b ? "round_b" : "round_a", 64'(rnd), 64'(e.rnd));
          chk(b ? "last_b" : "last_a", 64'(last), 64'(e.last));
        end
      end else begin
        stall[b]    = 1'b1;
        hold_key[b] = key;
        hold_rnd[b] = rnd;
      end
    end else begin
      stall[b] = 1'b0;
    end
    if (start_pend) stall[b] = 1'b0;
  endtask

  initial begin
    stall[0] = 1'b0;
    stall[1] = 1'b0;
    forever begin
      @(negedge clk);
      mon_step(1'b0, rst_a & if_a.Subkey_Valid, if_a.Subkey_Ready, if_a.Subkey_Out,
               if_a.Round_Out, if_a.Subkey_Last, if_a.Start & if_a.Start_Ready);
      mon_step(1'b1, rst_b & if_b.Subkey_Valid, if_b.Subkey_Ready, if_b.Subkey_Out,
               if_b.Round_Out, if_b.Subkey_Last, if_b.Start & if_b.Start_Ready);
    end
  end

  task automatic start_a(input logic [63:0] key, input logic dec);
    @(posedge clk); #1;
    chk("start_ready_idle_a", 64'(if_a.Start_Ready), 64'd1);
    if_a.Key_Input = key;
    if_a.Decrypt   = dec;
    if_a.Start     = 1'b1;
    push_run(key, dec, 1'b0);
    @(posedge clk); #1;
    if_a.Start     = 1'b0;
    if_a.Key_Input = {$urandom, $urandom};
    if_a.Decrypt   = 1'($urandom_range(0, 1));
    chk("valid_latency_a", 64'(if_a.Subkey_Valid), 64'd1);
    chk("busy_a", 64'(if_a.Busy), 64'd1);
  endtask

  // mode 0: ready tied high; 1: random; 2: five low cycles at round 3 then random.
  task automatic wait_idle_a(input int mode);
    int low;
    bit bp_done;
    low = 0;
    bp_done = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(posedge clk); #1;
      if (!if_a.Busy) return;
      case (mode)
        0: if_a.Subkey_Ready = 1'b1;
        1: if_a.Subkey_Ready = 1'($urandom_range(0, 1));
        default: begin
          if (!bp_done && if_a.Round_Out == 4'd3) begin
            if_a.Subkey_Ready = 1'b0;
            low++;
            if (low == 5) bp_done = 1'b1;
          end else begin
            if_a.Subkey_Ready = bp_done ? 1'($urandom_range(0, 1)) : 1'b1;
          end
        end
      endcase
    end
    fail_now("timeout_wait_idle_a");
  endtask

  task automatic wait_round_a(input logic [3:0] r);
    for (int n = 0; n < 100; n++) begin
      @(posedge clk); #1;
      if (if_a.Busy && if_a.Round_Out == r) return;
    end
    fail_now("timeout_wait_round_a");
  endtask

  // Directed known-key run with ready tied high; checks published subkeys directly.
  task automatic known_run_a(input logic dec, input logic [47:0] r0, input logic [47:0] r1,
                             input logic [47:0] r15);
    if_a.Subkey_Ready = 1'b1;
    start_a(KEY0, dec);
    for (int r = 0; r < 16; r++) begin
      chk("known_valid_a", 64'(if_a.Subkey_Valid), 64'd1);
      chk("known_last_a", 64'(if_a.Subkey_Last), 64'(r == 15));
      if (r == 0)  chk("known_round0_a", 64'(if_a.Subkey_Out), 64'(r0));
      if (r == 1)  chk("known_round1_a", 64'(if_a.Subkey_Out), 64'(r1));
      if (r == 15) chk("known_round15_a", 64'(if_a.Subkey_Out), 64'(r15));
      @(posedge clk); #1;
    end
    chk("known_done_valid_a", 64'(if_a.Subkey_Valid), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a = 1'b0;
    rst_b = 1'b0;
    if_a.Key_Input = '0; if_a.Start = 1'b0; if_a.Decrypt = 1'b0; if_a.Subkey_Ready = 1'b0;
    if_b.Key_Input = '0; if_b.Start = 1'b0; if_b.Decrypt = 1'b0; if_b.Subkey_Ready = 1'b0;

    // Reset state
    #3;
    chk("rst_valid_a", 64'(if_a.Subkey_Valid), 64'd0);
    chk("rst_subkey_a", 64'(if_a.Subkey_Out), 64'd0);
    chk("rst_round_a", 64'(if_a.Round_Out), 64'd0);
    chk("rst_busy_a", 64'(if_a.Busy), 64'd0);
    chk("rst_ready_a", 64'(if_a.Start_Ready), 64'd0);
    @(negedge clk);
    rst_a = 1'b1;
    rst_b = 1'b1;
    #1;
    chk("post_rst_ready_a", 64'(if_a.Start_Ready), 64'd1);
    chk("post_rst_ready_b", 64'(if_b.Start_Ready), 64'd1);

    // Known-answer encrypt and decrypt
    known_run_a(1'b0, K_1, K_2, K_16);
    known_run_a(1'b1, K_16, K_15, K_1);

    // Backpressure: compare to the unstalled sequence, values stable during stalls
    if_a.Subkey_Ready = 1'b1;
    start_a(KEY0, 1'b0);
    wait_idle_a(2);

    // Start while busy is ignored, including on the round-15 acceptance cycle
    if_a.Subkey_Ready = 1'b1;
    start_a(KEY0, 1'b0);
    wait_round_a(4'd7);
    if_a.Start = 1'b1; if_a.Key_Input = KEY_X; if_a.Decrypt = 1'b1;
    chk("ready_busy_a", 64'(if_a.Start_Ready), 64'd0);
    @(posedge clk); #1;
    if_a.Start = 1'b0;
    wait_round_a(4'd15);
    if_a.Start = 1'b1; if_a.Key_Input = KEY_X;
    chk("ready_last_a", 64'(if_a.Start_Ready), 64'd0);
    @(posedge clk); #1;
    if_a.Start = 1'b0;
    chk("after_last_valid_a", 64'(if_a.Subkey_Valid), 64'd0);
    chk("after_last_busy_a", 64'(if_a.Busy), 64'd0);

    // Asynchronous reset mid-run
    start_a({$urandom, $urandom}, 1'b0);
    wait_round_a(4'd9);
    #2;
    rst_a = 1'b0;
    #1;
    chk("async_rst_valid_a", 64'(if_a.Subkey_Valid), 64'd0);
    chk("async_rst_subkey_a", 64'(if_a.Subkey_Out), 64'd0);
    chk("async_rst_round_a", 64'(if_a.Round_Out), 64'd0);
    chk("async_rst_busy_a", 64'(if_a.Busy), 64'd0);
    chk("async_rst_last_a", 64'(if_a.Subkey_Last), 64'd0);
    q_a.delete();
    @(posedge clk);
    @(negedge clk);
    rst_a = 1'b1;
    #1;
    chk("rerelease_ready_a", 64'(if_a.Start_Ready), 64'd1);
    start_a(KEY0, 1'b0);
    chk("fresh_round0_a", 64'(if_a.Subkey_Out), 64'(K_1));
    wait_idle_a(1);

    // Randomized keys, modes and backpressure
    for (int t = 0; t < 8; t++) begin
      if_a.Subkey_Ready = 1'($urandom_range(0, 1));
      start_a({$urandom, $urandom}, 1'($urandom_range(0, 1)));
      wait_idle_a(1);
    end

    // Restart instance: relaunch in decrypt order at round 5
    @(posedge clk); #1;
    if_b.Subkey_Ready = 1'b1;
    if_b.Key_Input = KEY0; if_b.Decrypt = 1'b0; if_b.Start = 1'b1;
    push_run(KEY0, 1'b0, 1'b1);
    @(posedge clk); #1;
    if_b.Start = 1'b0;
    for (int n = 0; n < 50 && !(if_b.Busy && if_b.Round_Out == 4'd5); n++) begin
      @(posedge clk); #1;
    end
    chk("restart_at_round5_b", 64'(if_b.Round_Out), 64'd5);
    chk("ready_busy_b", 64'(if_b.Start_Ready), 64'd1);
    if_b.Subkey_Ready = 1'b0;
    if_b.Key_Input = KEY0; if_b.Decrypt = 1'b1; if_b.Start = 1'b1;
    q_b.delete();
    push_run(KEY0, 1'b1, 1'b1);
    @(posedge clk); #1;
    if_b.Start = 1'b0;
    if_b.Subkey_Ready = 1'b1;
    chk("restart_valid_b", 64'(if_b.Subkey_Valid), 64'd1);
    chk("restart_round_b", 64'(if_b.Round_Out), 64'd0);
    chk("restart_subkey_b", 64'(if_b.Subkey_Out), 64'(K_16));
    for (int n = 0; n < 50 && if_b.Busy; n++) begin
      @(posedge clk); #1;
    end
    chk("restart_done_busy_b", 64'(if_b.Busy), 64'd0);

    repeat (2) @(posedge clk);
    #1;
    chk("queue_empty_a", 64'(q_a.size()), 64'd0);
    chk("queue_empty_b", 64'(q_b.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/des_key_schedule.md
Name: des_key_schedule

Overview:
- Iterative DES round-key generator. It sits directly upstream of the DES round datapath and feeds it one 48-bit subkey per round over a valid/ready handshake.
- Applies PC-1 once at launch. Each round it rotates C/D, applies PC-2 and presents the subkey tagged with its round index.
- Supports encrypt order (K1..K16) and decrypt order (K16..K1) without precomputing all 16 keys.
- Bit numbering follows DES convention: bit 1 is the MSB, vectors are declared [N:1].

Parameters:
- ALLOW_RESTART, 0: when 1, Start accepted in any state aborts the current schedule and relaunches; when 0, Start is accepted only in IDLE.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset; asserts immediately, deasserts synchronously to clk.
- Key_Input  in  64  DES key including parity bits 8,16,..,64 (parity ignored).
- Start  in  1  launch request; sampled with Key_Input and Decrypt.
- Decrypt  in  1  0 = encrypt order, 1 = decrypt order.
- Start_Ready  out  1  block will accept Start this cycle.
- Subkey_Out  out  48  current round subkey, PC-2 output [48:1].
- Round_Out  out  4  index of the presented subkey in issue order, 0..15.
- Subkey_Valid  out  1  Subkey_Out/Round_Out valid.
- Subkey_Ready  in  1  consumer accepts the subkey when Subkey_Valid & Subkey_Ready.
- Subkey_Last  out  1  high with Subkey_Valid when Round_Out = 15.
- Busy  out  1  state != IDLE.

Behaviour:
- Reset values: all outputs 0, except Start_Ready = 1 once rst is released. C/D registers and round counter are 0. State = IDLE.
- States are IDLE and RUN. Start_Ready = (state == IDLE) | ALLOW_RESTART.
- Start acceptance: Start & Start_Ready at edge N.
  - Latch Decrypt into an internal mode register.
  - {C,D} <= first_shift(PC1(Key_Input)). Encrypt rotates left 1. Decrypt rotates 0, because C16D16 = C0D0.
  - Round counter <= 0; state <= RUN.
- RUN:
  - Subkey_Valid = 1; Subkey_Out = PC2(C,D), combinational from the C/D registers only; Round_Out = counter.
  - Latency from Start acceptance to first Subkey_Valid is 1 cycle (valid after edge N).
- Hold: while Subkey_Valid & !Subkey_Ready, all outputs and registers hold unchanged (stall of any length).
- Advance on acceptance with counter r < 15: counter <= r+1 and C/D rotate by the amount for issue index r+1.
  - Encrypt shift for issue index i (0-based): rotate left s[i], with s = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - Decrypt shift for issue index i >= 1: rotate right s[16-i]. This gives the sequence 1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - C and D are each 28-bit and rotate independently.
- Acceptance at r = 15 (Subkey_Last): state <= IDLE; Subkey_Valid drops the next cycle.
  - With ALLOW_RESTART = 0, a Start in the same cycle is not accepted (Start_Ready = 0 that cycle).
  - With ALLOW_RESTART = 1, Start takes priority and relaunches.
- Restart mid-run (ALLOW_RESTART = 1): the in-flight schedule is discarded, no Subkey_Last is issued for it, and the new first subkey appears the next cycle.
- Decrypt and Key_Input changes after acceptance have no effect until the next Start.
- rst asserted mid-run: immediate return to reset values; no partial output.

Decomposition:
- Shared package des_pkg:
  - PC1 table (56 entries) and PC2 table (48 entries) as constant index arrays.
  - Encrypt shift schedule (16 entries) and state enum {IDLE, RUN}.
  - Subkey width constant 48 and half-key width 28.
- One natural sub-module: des_pc2, a combinational 56→48 permutation, reusable by a future precomputed-key variant. PC-1 stays inline.

Test Plan:
- Encrypt, key 133457799BBCDFF1, Subkey_Ready tied 1:
  - Round 0 = 1B02EFFC7072, round 1 = 79AED9DBC9E5, round 15 = CB3D8B0E17F5.
  - Subkey_Last only on round 15; 16 consecutive valid cycles, starting 1 cycle after Start.
- Decrypt, same key: round 0 = CB3D8B0E17F5, round 1 = BF918D3D3F0A, round 15 = 1B02EFFC7072.
- Backpressure, encrypt: Subkey_Ready low for 5 cycles at round 3, then random toggling.
  - Subkey_Out/Round_Out are stable during every stall.
  - The full 16-key sequence matches the unstalled run exactly, with no skip or duplicate.
- Start while Busy, ALLOW_RESTART = 0: Start pulsed at round 7 with a different key is ignored and the original sequence completes. Start asserted on the round-15 acceptance cycle is also ignored.
- ALLOW_RESTART = 1: Start at round 5 with Decrypt = 1 → next cycle Round_Out = 0, Subkey_Out = CB3D8B0E17F5.
- rst driven low asynchronously mid-cycle at round 9: outputs go to 0 immediately and Busy = 0. After release, a fresh Start reproduces round 0 = 1B02EFFC7072.
